// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input mdu_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial_hi, multiplier}, opnd = multiplicand.
// Divide:   acc[WIDTH-1:0] = dividend shifting out / quotient shifting in,
//           opnd = divisor, rem = partial remainder.
module mdu_iter_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  input  logic [WIDTH:0]       rem_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH:0]       rem_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_opnd;
  logic             div_borrow;

  // Select the multiply or divide iteration result.
  always_comb begin
    mul_sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : '0)};
    div_shift  = {rem_i, acc_i[WIDTH-1]};
    div_opnd   = {2'b00, opnd_i};
    div_borrow = (div_shift < div_opnd);
    acc_o      = acc_i;
    rem_o      = rem_i;
    if (is_div_i) begin
      rem_o = div_borrow ? div_shift[WIDTH:0] : (WIDTH+1)'(div_shift - div_opnd);
      acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], ~div_borrow};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M-style multiply/divide unit with valid/ready handshakes,
// divide fast path, flush and output backpressure.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP-1:0]    op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int unsigned   CW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e           state_q, state_d;
  mdu_op_e              op_q, op_d, op_in;
  logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH:0]       rem_q, rem_d, rem_step;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]     abs_a, abs_b, quo_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  assign op_in     = mdu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div(op_q)),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .rem_i    (rem_q),
    .acc_o    (acc_step),
    .rem_o    (rem_step)
  );

  // Operand sign/magnitude at accept and signed fix-up of the finished magnitudes.
  always_comb begin
    a_neg    = is_signed_a(op_in) && rs1[WIDTH-1];
    b_neg    = is_signed_b(op_in) && rs2[WIDTH-1];
    abs_a    = a_neg ? -rs1 : rs1;
    abs_b    = b_neg ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) && (rs1 == MIN_NEG) && (rs2 == '1);
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = ((neg_a_q ^ neg_b_q) && (opnd_q != '0)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // Next-state and datapath loads; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d    = op_in;
            neg_a_d = a_neg;
            neg_b_d = b_neg;
            cnt_d   = CW'(WIDTH - 1);
            rem_d   = '0;
            // Divide keeps the divisor in opnd and dividend in acc; multiply swaps roles.
            if (is_div(op_in)) begin
              opnd_d = abs_b;
              acc_d  = {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd_d = abs_a;
              acc_d  = {{WIDTH{1'b0}}, abs_b};
            end
            if (is_div(op_in) && div_zero) begin
              result_d = op_in[1] ? rs1 : '1;
              state_d  = ST_DONE;
            end else if (div_ovf) begin
              result_d = op_in[1] ? '0 : rs1;
              state_d  = ST_DONE;
            end else begin
              state_d  = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc_d = acc_step;
          rem_d = rem_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = ST_FIX;
        end
        ST_FIX: begin
          case (op_q)
            OP_MUL:                       result_d = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              result_d = quo_fix;
            default:                      result_d = WIDTH'(neg_a_q ? -rem_q : rem_q);
          endcase
          state_d = ST_DONE;
        end
        default: begin
          if (out_ready) state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else begin
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative, parametrised integer multiply/divide unit implementing the eight RV32M operations. It sits beside the single-cycle ALU in the execute stage.
- The core's control logic issues an operation through a valid/ready handshake, stalls fetch while the unit is busy, and writes the result back when the unit presents it on a valid/ready output handshake.
- Generalises the ALU in width and mode with multi-cycle sequencing, flush, and backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are even, 8..64.
- OP, 3, opcode width (funct3 encoding).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; single clock domain
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request (high only in IDLE)
- op  input  OP  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  WIDTH  operand A (multiplicand/dividend)
- rs2  input  WIDTH  operand B (multiplier/divisor)
- flush  input  1  abort any in-flight operation
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  operation result
- busy  output  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0; all internal registers cleared. Reset mid-operation discards the operation silently.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On in_valid&&in_ready (accept edge E0), latch op, sign flags and absolute operand values. Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; DIV/REM signed.
  - Load the iteration counter with WIDTH-1 and go to CALC.
- Fast path, checked at E0 for divide ops only:
  - rs2==0: quotient = all ones, remainder = rs1.
  - Signed overflow (rs1 = 1 followed by WIDTH-1 zeros, rs2 = all ones, DIV/REM): quotient = rs1, remainder = 0.
  - Result is loaded and state goes directly to DONE, so out_valid is high after E0.
- CALC: one iteration per cycle, for edges E1..E_WIDTH.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring step, shifting the remainder left, trial-subtracting the divisor, and shifting the quotient bit in.
  - The counter decrements each cycle; when it reaches 0, go to FIX.
- FIX, edge E_WIDTH+1:
  - Apply sign correction by two's-complement negation. The product is negated if the operand signs differ. The quotient is negated if the signs differ and the divisor is nonzero. The remainder takes the dividend's sign.
  - Select the output: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - Register the selection into result and go to DONE.
- Latency: out_valid rises after edge E_WIDTH+1, i.e. WIDTH+1 cycles after accept (33 at WIDTH=32). Fast path takes 1 cycle.
- DONE: out_valid=1 and result is held stable while out_ready=0. When out_valid&&out_ready, go to IDLE; in_ready is high the next cycle. There is no same-cycle accept of a new op in DONE.
- flush has priority over every transition. In any state, go to IDLE next edge and clear out_valid. A result in DONE is dropped. A flush in the same cycle as in_valid in IDLE suppresses the accept.
- in_valid outside IDLE is ignored. op/rs1/rs2 changes after accept have no effect.
- Widths:
  - The accumulator is 2*WIDTH bits; the divider partial remainder is WIDTH+1 bits.
  - The counter is $clog2(WIDTH) bits.
  - Negation of the most-negative value wraps, with no saturation.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e enum (the eight funct3 codes)
  - mdu_state_e enum (IDLE/CALC/FIX/DONE)
  - helper functions is_div(op), is_signed_a(op), is_signed_b(op)
- One combinational sub-module, mdu_iter_step. It computes a single multiply or divide iteration and returns the next accumulator/remainder/quotient. mul_div_unit holds the FSM, registers and sign fix.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB. out_valid rises exactly 33 cycles after accept; in_ready=0 throughout.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM 0xFFFFFFF9%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5%0 -> 5, out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, also 1-cycle latency.
- Backpressure: out_ready low for 5 cycles in DONE -> result and out_valid held constant, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Flush at cycle 10 of CALC -> IDLE next edge, no out_valid. rst_n low at cycle 20 of a DIV -> all outputs at reset values immediately. A subsequent MUL 3×4 returns 12.
